// File: rtl/seq_detect_param.sv
// Serial pattern detector: shifts accepted samples into a history register and
// raises a registered one-cycle flag whenever the newest PAT_LEN samples equal PATTERN.
module seq_detect_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b110,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_seq,
    input  logic             clear,
    output logic             out_seq,
    output logic [CNT_W-1:0] match_count
);

    generate
        if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
            $error("seq_detect_param: PAT_LEN must be within 2..16");
        end
    endgenerate

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

    typedef enum logic {
        IDLE,
        HIT
    } state_t;

    state_t             state, state_next;
    logic [PAT_LEN-1:0] hist, hist_next;
    logic [FILL_W-1:0]  fill, fill_next;
    logic [CNT_W-1:0]   count_next;
    logic [PAT_LEN-1:0] shifted;
    logic               hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
        end else begin
            state       <= state_next;
            hist        <= hist_next;
            fill        <= fill_next;
            match_count <= count_next;
        end
    end

    // fill gating keeps stale or reset-zero history from ever completing a match
    always_comb begin
        shifted    = {hist[PAT_LEN-2:0], in_seq};
        hit        = in_valid && !clear && (fill >= FILL_LAST) && (shifted == PATTERN);
        state_next = IDLE;
        hist_next  = hist;
        fill_next  = fill;
        count_next = match_count;

        if (clear) begin
            hist_next  = '0;
            fill_next  = '0;
            count_next = '0;
        end else if (in_valid) begin
            hist_next = shifted;
            if (hit && !OVERLAP) begin
                fill_next = '0;
            end else if (fill != FILL_MAX) begin
                fill_next = fill + FILL_W'(1);
            end
            if (hit) begin
                state_next = HIT;
                if (match_count != '1) begin
                    count_next = match_count + CNT_W'(1);
                end
            end
        end
    end

    assign out_seq = (state == HIT);

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: five detector configurations share one input stream driven
// from a table of vectors; expected flags/counts travel through a scoreboard queue.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic reset, in_valid, in_seq, clear;

    logic       out_def, out_ov, out_nov, out_zero, out_sat;
    logic [7:0] cnt_def, cnt_ov, cnt_nov, cnt_zero;
    logic [1:0] cnt_sat;

    always #5 clk = ~clk;

    seq_detect_param u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_seq(in_seq), .clear(clear),
        .out_seq(out_def), .match_count(cnt_def)
    );

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_seq(in_seq), .clear(clear),
        .out_seq(out_ov), .match_count(cnt_ov)
    );

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_seq(in_seq), .clear(clear),
        .out_seq(out_nov), .match_count(cnt_nov)
    );

    seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b000), .OVERLAP(1'b1), .CNT_W(8)) u_zero (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_seq(in_seq), .clear(clear),
        .out_seq(out_zero), .match_count(cnt_zero)
    );

    seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b110), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_seq(in_seq), .clear(clear),
        .out_seq(out_sat), .match_count(cnt_sat)
    );

    // exp bits: {def, ov, nov, zero}; the CNT_W=2 instance shares the default pattern
    typedef struct {
        logic       valid;
        logic       seq;
        logic       clr;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0] outs;
        logic [7:0] c_def, c_ov, c_nov, c_zero, c_sat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int n_total = 0;
    int n_pass  = 0;
    int m_def = 0, m_ov = 0, m_nov = 0, m_zero = 0, m_sat = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic zero_model();
        m_def = 0; m_ov = 0; m_nov = 0; m_zero = 0; m_sat = 0;
    endtask

    task automatic add(input logic v, input logic s, input logic c, input logic [3:0] m);
        vec_t r;
        r.valid = v; r.seq = s; r.clr = c; r.exp = m;
        vecs.push_back(r);
    endtask

    task automatic step(input string tag, input logic v, input logic s, input logic c,
                        input logic [3:0] m);
        exp_t e;
        exp_t got;
        @(negedge clk);
        in_valid = v; in_seq = s; clear = c;
        if (c) begin
            zero_model();
            e.outs = '0;
        end else begin
            e.outs = {m, m[3]};
            if (m[3] && m_def  < 255) m_def++;
            if (m[2] && m_ov   < 255) m_ov++;
            if (m[1] && m_nov  < 255) m_nov++;
            if (m[0] && m_zero < 255) m_zero++;
            if (m[3] && m_sat  < 3)   m_sat++;
        end
        e.c_def = 8'(m_def); e.c_ov = 8'(m_ov); e.c_nov = 8'(m_nov);
        e.c_zero = 8'(m_zero); e.c_sat = 8'(m_sat);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, " out_def"},  {7'd0, out_def},  {7'd0, got.outs[4]});
        chk({tag, " out_ov"},   {7'd0, out_ov},   {7'd0, got.outs[3]});
        chk({tag, " out_nov"},  {7'd0, out_nov},  {7'd0, got.outs[2]});
        chk({tag, " out_zero"}, {7'd0, out_zero}, {7'd0, got.outs[1]});
        chk({tag, " out_sat"},  {7'd0, out_sat},  {7'd0, got.outs[0]});
        chk({tag, " cnt_def"},  cnt_def,  got.c_def);
        chk({tag, " cnt_ov"},   cnt_ov,   got.c_ov);
        chk({tag, " cnt_nov"},  cnt_nov,  got.c_nov);
        chk({tag, " cnt_zero"}, cnt_zero, got.c_zero);
        chk({tag, " cnt_sat"},  {6'd0, cnt_sat}, got.c_sat);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " out_def"},  {7'd0, out_def},  8'd0);
        chk({tag, " out_zero"}, {7'd0, out_zero}, 8'd0);
        chk({tag, " cnt_def"},  cnt_def,  8'd0);
        chk({tag, " cnt_ov"},   cnt_ov,   8'd0);
        chk({tag, " cnt_sat"},  {6'd0, cnt_sat}, 8'd0);
    endtask

    initial begin
        // 1,1,0 on defaults
        add(1, 1, 0, 4'b0000); add(1, 1, 0, 4'b0000); add(1, 0, 0, 4'b1000);
        add(0, 0, 1, 4'b0000);
        // 1,0,1,0,1,0: 1010 overlapping twice, non-overlapping once
        add(1, 1, 0, 4'b0000); add(1, 0, 0, 4'b0000); add(1, 1, 0, 4'b0000);
        add(1, 0, 0, 4'b0110); add(1, 1, 0, 4'b0000); add(1, 0, 0, 4'b0100);
        add(0, 0, 1, 4'b0000);
        // 1, three idle cycles with toggling data, 1, 0
        add(1, 1, 0, 4'b0000); add(0, 0, 0, 4'b0000); add(0, 1, 0, 4'b0000);
        add(0, 0, 0, 4'b0000); add(1, 1, 0, 4'b0000); add(1, 0, 0, 4'b1000);
        add(0, 1, 0, 4'b0000);
        // 1,1 then clear alongside a valid 0, then 0: no match
        add(1, 1, 0, 4'b0000); add(1, 1, 0, 4'b0000); add(1, 0, 1, 4'b0000);
        add(1, 0, 0, 4'b0000);
        // zero pattern needs three fresh zeros, then overlaps
        add(1, 0, 0, 4'b0000); add(1, 0, 0, 4'b0001); add(1, 0, 0, 4'b0001);
        add(0, 0, 1, 4'b0000);
        // five 110 matches: CNT_W=2 counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            add(1, 1, 0, 4'b0000); add(1, 1, 0, 4'b0000); add(1, 0, 0, 4'b1000);
        end

        reset = 1'b0; in_valid = 1'b0; in_seq = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].seq, vecs[i].clr, vecs[i].exp);
        end

        // asynchronous reset mid-pattern clears counts without a clock edge
        step("pre_rst_a", 1, 1, 0, 4'b0000);
        step("pre_rst_b", 1, 1, 0, 4'b0000);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        zero_model();
        @(negedge clk);
        reset = 1'b1;
        // a 0 that would have completed 110 must not match; zero pattern fills from scratch
        step("post_rst_0a", 1, 0, 0, 4'b0000);
        step("post_rst_0b", 1, 0, 0, 4'b0000);
        step("post_rst_0c", 1, 0, 0, 4'b0001);
        step("post_rst_idle", 0, 0, 0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule
